data_mem_ctl: RTL and testbench

- Parametrised single-port data memory for the CPU datapath.
- Zeroing uses a sequential clear engine, one word per cycle, instead of a parallel reset of every word.
- Adds a req/ready handshake, registered reads with a valid strobe, out-of-range detection and a configurable bank of debug tap outputs.
- Sits between the CPU load/store path and the top-level debug/LED observation ports.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 32 +++
 rtl/data_mem_ctl.sv | 115 +++++++++++
 tb/tb_data_mem_ctl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the CPU data memory: controller states and the
// default geometry used by the CPU top.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int DMEM_DATA_W = 24;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DEPTH  = 256;

endpackage

// File: rtl/dmem_array.sv
// Plain synchronous-write storage array with one combinational read port and
// N_TAP combinational tap ports. The array itself has no reset.
module dmem_array #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int N_TAP    = 3,
  parameter int TAP_BASE = 0
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [ADDR_W-1:0]         i_waddr,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic [ADDR_W-1:0]         i_raddr,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [N_TAP*DATA_W-1:0]   o_taps
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Out-of-range read addresses are masked by the controller.
  assign o_rdata = r_mem[i_raddr];

  for (genvar i = 0; i < N_TAP; i++) begin : g_tap
    assign o_taps[i*DATA_W +: DATA_W] = r_mem[ADDR_W'(TAP_BASE + i)];
  end

endmodule

// File: rtl/data_mem_ctl.sv
// CPU data memory controller: sequential clear engine, req/ready access port,
// registered reads with rvalid, out-of-range error strobe and debug taps.
module data_mem_ctl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int N_TAP    = 3,
  parameter int TAP_BASE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       din,
  output logic                    ready,
  output logic                    busy,
  output logic                    rvalid,
  output logic [DATA_W-1:0]       dout,
  output logic                    err,
  output logic [N_TAP*DATA_W-1:0] taps
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic                r_rvalid;
  logic                r_err;
  logic [DATA_W-1:0]   r_dout;

  logic                w_clearing;
  logic                w_in_range;
  logic                w_acc;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic [N_TAP*DATA_W-1:0] w_taps;

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_in_range = ({1'b0, addr} < DEPTH_L);
  // clr wins over a same-cycle request; requests during CLEAR are ignored.
  assign w_acc      = !w_clearing && !clr && req;

  // The clear engine owns the write port while CLEAR is active.
  assign w_we    = w_clearing || (w_acc && we && w_in_range);
  assign w_waddr = w_clearing ? r_clr_ptr : addr;
  assign w_wdata = w_clearing ? '0 : din;

  dmem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .N_TAP    (N_TAP),
    .TAP_BASE (TAP_BASE)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (addr),
    .o_rdata (w_rdata),
    .o_taps  (w_taps)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == LAST_PTR) begin
            r_clr_ptr <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_dout    <= '0;
          end else if (req) begin
            r_err <= !w_in_range;
            if (!we) begin
              r_rvalid <= 1'b1;
              r_dout   <= w_in_range ? w_rdata : '0;
            end
          end
        end
      endcase
    end
  end

  assign ready  = (r_state == ST_IDLE);
  assign busy   = w_clearing;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign dout   = r_dout;
  // Hide array contents until the clear engine has zeroed them.
  assign taps   = w_clearing ? '0 : w_taps;

endmodule

// File: tb/tb_data_mem_ctl.sv
// Scoreboard bench for data_mem_ctl: a full-depth instance and a DEPTH=200
// instance share one stimulus stream.
module tb_data_mem_ctl;

  localparam int DW = 24;
  localparam int AW = 8;
  localparam int D2 = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic req = 1'b0;
  logic we  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;

  logic          ready, busy, rvalid, err;
  logic [DW-1:0] dout;
  logic [3*DW-1:0] taps;
  logic          ready_b, busy_b, rvalid_b, err_b;
  logic [DW-1:0] dout_b;
  logic [3*DW-1:0] taps_b;

  data_mem_ctl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .N_TAP(3), .TAP_BASE(0)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr), .din(din),
    .ready(ready), .busy(busy), .rvalid(rvalid), .dout(dout), .err(err), .taps(taps)
  );

  data_mem_ctl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D2), .N_TAP(3), .TAP_BASE(0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr), .din(din),
    .ready(ready_b), .busy(busy_b), .rvalid(rvalid_b), .dout(dout_b), .err(err_b), .taps(taps_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;

  rd_t           q[$];
  rd_t           q2[$];
  int            eq2[$];
  logic [DW-1:0] mdl [256];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read/error scoreboard for both instances.
  always @(negedge clk) begin
    rd_t e;
    int  c;
    if (rvalid === 1'b1) begin
      if (q.size() == 0) chk("rvalid_spurious", 128'(1), 128'(0));
      else begin
        e = q.pop_front();
        chk("rd_cycle", 128'(cyc), 128'(e.cyc));
        chk("rd_data", 128'(dout), 128'(e.data));
      end
    end
    if (err === 1'b1) chk("err_spurious", 128'(1), 128'(0));
    if (rvalid_b === 1'b1) begin
      if (q2.size() == 0) chk("rvalid_b_spurious", 128'(1), 128'(0));
      else begin
        e = q2.pop_front();
        chk("rd_b_cycle", 128'(cyc), 128'(e.cyc));
        chk("rd_b_data", 128'(dout_b), 128'(e.data));
      end
    end
    if (err_b === 1'b1) begin
      if (eq2.size() == 0) chk("err_b_spurious", 128'(1), 128'(0));
      else begin
        c = eq2.pop_front();
        chk("err_b_cycle", 128'(cyc), 128'(c));
      end
    end
  end

  task automatic acc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_t e;
    req = 1'b1; we = w; addr = a; din = d;
    if (w) mdl[a] = d;
    else begin
      e.data = mdl[a];
      e.cyc  = cyc + 1;
      q.push_back(e);
      e.data = (a < AW'(D2)) ? mdl[a] : '0;
      q2.push_back(e);
    end
    if (a >= AW'(D2)) eq2.push_back(cyc + 1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n, n2, bad;
    n = 0; n2 = 0; bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (busy_b) begin
        n2++;
        if (taps_b != '0) bad++;
      end
      if (!busy) break;
      n++;
      if (taps != '0 || ready) bad++;
    end
    chk({tag, "_cycles"}, 128'(n), 128'(256));
    chk({tag, "_cycles_b"}, 128'(n2), 128'(D2));
    chk({tag, "_taps_zero"}, 128'(bad), 128'(0));
    chk({tag, "_ready"}, 128'(ready), 128'(1));
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  initial begin
    logic [3*DW-1:0] save_b;
    foreach (mdl[i]) mdl[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(1));
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_rvalid", 128'(rvalid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_dout", 128'(dout), 128'(0));
    chk("rst_taps", 128'(taps), 128'(0));
    rst = 1'b0;
    wait_clear("init");

    // Read of a freshly cleared word, then write/read-back
    acc(1'b0, 8'h05, '0);
    acc(1'b1, 8'h01, 24'hABCDEF);
    acc(1'b0, 8'h01, '0);
    @(negedge clk);
    chk("taps_w1", 128'(taps[DW +: DW]), 128'(24'hABCDEF));

    // Back-to-back reads
    acc(1'b1, 8'h00, 24'h000011);
    acc(1'b1, 8'h02, 24'h000022);
    acc(1'b0, 8'h00, '0);
    acc(1'b0, 8'h02, '0);
    @(negedge clk);
    chk("taps", 128'(taps), 128'({mdl[2], mdl[1], mdl[0]}));
    chk("taps_b", 128'(taps_b), 128'({mdl[2], mdl[1], mdl[0]}));

    // Out-of-range on the DEPTH=200 instance, in-range on the full one
    save_b = taps_b;
    acc(1'b1, 8'hC8, 24'h123456);
    acc(1'b0, 8'hC8, '0);
    acc(1'b0, 8'h01, '0);
    @(negedge clk);
    chk("taps_b_keep", 128'(taps_b), 128'(save_b));

    // clr with a simultaneous write request
    clr = 1'b1; req = 1'b1; we = 1'b1; addr = 8'h03; din = 24'h000777;
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b0; we = 1'b0;
    wait_clear("clr");
    chk("clr_dout", 128'(dout), 128'(0));
    chk("clr_dout_b", 128'(dout_b), 128'(0));
    chk("clr_taps", 128'(taps), 128'(0));
    for (int i = 0; i < 4; i++) acc(1'b0, AW'(i), '0);
    acc(1'b0, 8'hC8, '0);

    // Reset 10 cycles into CLEAR, with requests ignored meanwhile
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b1; we = 1'b0; addr = 8'hC8;
    repeat (10) @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_busy", 128'(busy), 128'(1));
    chk("rst2_rvalid", 128'(rvalid), 128'(0));
    chk("rst2_err_b", 128'(err_b), 128'(0));
    rst = 1'b0;
    wait_clear("rst2");
    acc(1'b0, 8'h01, '0);
    repeat (3) @(negedge clk);

    chk("q_empty", 128'(q.size()), 128'(0));
    chk("q2_empty", 128'(q2.size()), 128'(0));
    chk("eq2_empty", 128'(eq2.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
